id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath/PC width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ID inputs: id_valid in 1; id_pc, id_rs1_data, id_rs2_data, id_imm in DATA_W each; id_rs1, id_rs2, id_rd in REG_W each; id_uses_rs1, id_uses_rs2 in 1 each, source operand actually read.
REQ-006 SHALL have ID control inputs: id_alu_op in 4; id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch in 1 each.
REQ-007 SHALL have flush  in  1: branch/jump resolved taken in EX; squashes the instruction in ID.
REQ-008 SHALL have registered EX outputs ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd and all control fields, mirroring REQ-005/006 widths; ex_rs1/ex_rs2 drive the forwarding unit's rs1/rs2.
REQ-009 SHALL have stall  out  1, combinational: hold PC and IF/ID this cycle.
REQ-010 SHALL have stall_cnt and bubble_cnt  out  CNT_W each: performance counters.

Function
REQ-011 SHALL detect load-use when ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-012 SHALL drive stall=1 iff load-use is detected and flush=0; flush has priority.
REQ-013 SHALL, on each rising edge with no stall and no flush, load all ID fields into the EX registers, one-cycle latency.
REQ-014 SHALL, on a stall or flush edge, load a bubble: ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=ex_branch=0, ex_rd=0; data fields don't-care but held at 0.
REQ-015 SHALL stall at most one consecutive cycle per load: the bubble clears ex_mem_read, so the held instruction issues next cycle.
REQ-016 SHALL treat id_valid=0 as a bubble on load, with no stall.
REQ-017 SHALL never stall on rd=x0: a load to x0 followed by a consumer of x0 does not stall.
REQ-018 SHALL increment stall_cnt by 1 each cycle stall=1, saturating at all-ones.
REQ-019 SHALL increment bubble_cnt by 1 each edge a bubble is loaded due to stall or flush, saturating at all-ones.
REQ-020 SHALL, with stall and flush both asserted at a load-use instant, perform a flush only: stall=0, bubble loaded, stall_cnt unchanged, bubble_cnt +1.

Reset
REQ-021 SHALL, on a clk edge with rst_n=0, clear every EX register and both counters to 0; ex_valid=0 forces stall=0 in the same cycle.
REQ-022 SHALL let reset override stall and flush; the first edge after rst_n=1 loads ID normally.

Structure
REQ-023 SHALL place the ALU-op encoding typedef and the control-bundle packed struct (alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch) in the shared pipeline package, reused by ex_mem/mem_wb stages.
REQ-024 SHALL implement load-use detection in one combinational sub-module hazard_detect, instantiated inside id_ex_stage; counters and registers stay in the top.

Verification
REQ-025 SHALL cover pass-through: id_valid=1, rd=5, imm=0x10, no hazard -> next cycle ex_rd=5, ex_imm=0x10, ex_valid=1, stall=0.
REQ-026 SHALL cover load-use: EX holds lw x6 (mem_read=1, rd=6), ID add rs1=6 uses_rs1=1 -> stall=1 one cycle, bubble in EX, add issued next cycle, stall_cnt=1.
REQ-027 SHALL cover the no-false-stall cases: same as REQ-026 with uses_rs1=0, or with rd=0 -> stall=0.
REQ-028 SHALL cover flush priority: load-use plus flush=1 -> stall=0, ex_valid=0 next cycle, bubble_cnt=1, stall_cnt=0.
REQ-029 SHALL cover reset mid-stall: rst_n=0 during stall -> all EX outputs 0, counters 0, stall=0 the next cycle.
REQ-030 SHALL cover counter saturation: with CNT_W=2, 5 load-use events -> stall_cnt holds at 3.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline package.
// Holds the ALU-op encoding and the control bundle that travels down the
// pipeline. The ID/EX, EX/MEM and MEM/WB stages all register this same bundle.
package id_ex_stage_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX pipeline bus.
// The master drives the decoded instruction (id_*); the slave (the ID/EX stage)
// drives the registered EX copy (ex_*).
// Handshake: id_valid qualifies the whole id_* bundle. There is no ready signal;
// the stage's stall output is the only backpressure. While stall=1 the producer
// must hold PC and IF/ID so the same instruction is presented again next cycle.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // ID side
    logic                id_valid;
    logic [DATA_W-1:0]   id_pc;
    logic [DATA_W-1:0]   id_rs1_data;
    logic [DATA_W-1:0]   id_rs2_data;
    logic [DATA_W-1:0]   id_imm;
    logic [REG_W-1:0]    id_rs1;
    logic [REG_W-1:0]    id_rs2;
    logic [REG_W-1:0]    id_rd;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                id_alu_src;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_reg_write;
    logic                id_mem_to_reg;
    logic                id_branch;

    // EX side
    logic                ex_valid;
    logic [DATA_W-1:0]   ex_pc;
    logic [DATA_W-1:0]   ex_rs1_data;
    logic [DATA_W-1:0]   ex_rs2_data;
    logic [DATA_W-1:0]   ex_imm;
    logic [REG_W-1:0]    ex_rs1;
    logic [REG_W-1:0]    ex_rs2;
    logic [REG_W-1:0]    ex_rd;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_alu_src;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_reg_write;
    logic                ex_mem_to_reg;
    logic                ex_branch;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_alu_op, id_alu_src, id_mem_read, id_mem_write,
               id_reg_write, id_mem_to_reg, id_branch,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_alu_op, id_alu_src, id_mem_read, id_mem_write,
               id_reg_write, id_mem_to_reg, id_branch,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use detector.
// Ports: ex_valid/ex_mem_read/ex_rd describe the instruction now in EX;
// id_valid/id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 describe the one in ID;
// load_use is high when the ID instruction reads the register a load in EX
// has not yet produced.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired zero, so a load targeting it never produces a value.
    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                      && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and flush.
// Ports: clk, rst_n (synchronous active-low); flush squashes the ID
// instruction; stall (combinational) holds PC and IF/ID; stall_cnt and
// bubble_cnt are saturating performance counters; bus carries the ID inputs
// and the registered EX outputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    id_ex_stage_if.slave     bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              load_use;
    logic              bubble;
    logic              take;
    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl;
    logic              ex_valid_q;
    logic [DATA_W-1:0] ex_pc_q;
    logic [DATA_W-1:0] ex_rs1_data_q;
    logic [DATA_W-1:0] ex_rs2_data_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [REG_W-1:0]  ex_rs1_q;
    logic [REG_W-1:0]  ex_rs2_q;
    logic [REG_W-1:0]  ex_rd_q;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd_q),
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .load_use    (load_use)
    );

    // Flush wins: the ID instruction is squashed anyway, so holding it is pointless.
    assign stall  = load_use && !flush;
    assign bubble = load_use || flush;
    // An invalid ID slot also loads an all-zero bubble, but is not counted.
    assign take   = bus.id_valid && !bubble;

    always_comb begin
        id_ctrl            = '0;
        id_ctrl.alu_op     = alu_op_e'(bus.id_alu_op);
        id_ctrl.alu_src    = bus.id_alu_src;
        id_ctrl.mem_read   = bus.id_mem_read;
        id_ctrl.mem_write  = bus.id_mem_write;
        id_ctrl.reg_write  = bus.id_reg_write;
        id_ctrl.mem_to_reg = bus.id_mem_to_reg;
        id_ctrl.branch     = bus.id_branch;
    end

    // Bubbles clear every field, which also drops ex_mem_read so a held
    // consumer issues on the following cycle (at most one stall per load).
    always_ff @(posedge clk) begin
        if (!rst_n || !take) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_ctrl       <= '0;
        end else begin
            ex_valid_q    <= 1'b1;
            ex_pc_q       <= bus.id_pc;
            ex_rs1_data_q <= bus.id_rs1_data;
            ex_rs2_data_q <= bus.id_rs2_data;
            ex_imm_q      <= bus.id_imm;
            ex_rs1_q      <= bus.id_rs1;
            ex_rs2_q      <= bus.id_rs2;
            ex_rd_q       <= bus.id_rd;
            ex_ctrl       <= id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.ex_rs1_data   = ex_rs1_data_q;
    assign bus.ex_rs2_data   = ex_rs2_data_q;
    assign bus.ex_imm        = ex_imm_q;
    assign bus.ex_rs1        = ex_rs1_q;
    assign bus.ex_rs2        = ex_rs2_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
    assign bus.ex_alu_src    = ex_ctrl.alu_src;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_branch     = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (CNT_W=2 so counter saturation is reachable).
// Expected EX contents and counters are pushed into queues when each ID
// instruction is driven and popped after the following clock edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
    } snap_t;

    typedef struct packed {
        snap_t f;
        logic  uses_rs1;
        logic  uses_rs2;
        logic  flush;
    } stim_t;

    localparam int SNAP_W = $bits(snap_t);

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic [1:0] stall_cnt;
    logic [1:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .stall      (stall),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .bus        (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [SNAP_W-1:0] exp_q[$];
    logic [3:0]        cnt_q[$];
    snap_t             m_ex;
    logic [1:0]        m_sc;
    logic [1:0]        m_bc;
    logic              exp_stall;
    int                checks = 0;
    int                errors = 0;
    stim_t             seq[$];
    snap_t             got;
    snap_t             exp_s;
    logic [3:0]        exp_c;

    function automatic snap_t get_snap();
        snap_t s;
        s.valid      = bus.ex_valid;
        s.pc         = bus.ex_pc;
        s.rs1_data   = bus.ex_rs1_data;
        s.rs2_data   = bus.ex_rs2_data;
        s.imm        = bus.ex_imm;
        s.rs1        = bus.ex_rs1;
        s.rs2        = bus.ex_rs2;
        s.rd         = bus.ex_rd;
        s.alu_op     = bus.ex_alu_op;
        s.alu_src    = bus.ex_alu_src;
        s.mem_read   = bus.ex_mem_read;
        s.mem_write  = bus.ex_mem_write;
        s.reg_write  = bus.ex_reg_write;
        s.mem_to_reg = bus.ex_mem_to_reg;
        s.branch     = bus.ex_branch;
        return s;
    endfunction

    function automatic stim_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1, input logic u2,
                                 input logic mr, input logic fl);
        stim_t s;
        s.f.valid      = v;
        s.f.pc         = $urandom;
        s.f.rs1_data   = $urandom;
        s.f.rs2_data   = $urandom;
        s.f.imm        = $urandom;
        s.f.rs1        = rs1;
        s.f.rs2        = rs2;
        s.f.rd         = rd;
        s.f.alu_op     = 4'($urandom_range(0, 9));
        s.f.alu_src    = 1'($urandom);
        s.f.mem_read   = mr;
        s.f.mem_write  = 1'($urandom);
        s.f.reg_write  = 1'b1;
        s.f.mem_to_reg = mr;
        s.f.branch     = 1'($urandom);
        s.uses_rs1     = u1;
        s.uses_rs2     = u2;
        s.flush        = fl;
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.id_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ex  = '0;
        m_sc  = '0;
        m_bc  = '0;
        exp_q.delete();
        cnt_q.delete();
    endtask

    // Drives one ID slot and records what EX and the counters must hold after the next edge.
    task automatic drive(input stim_t s);
        logic lu;
        bus.id_valid      = s.f.valid;
        bus.id_pc         = s.f.pc;
        bus.id_rs1_data   = s.f.rs1_data;
        bus.id_rs2_data   = s.f.rs2_data;
        bus.id_imm        = s.f.imm;
        bus.id_rs1        = s.f.rs1;
        bus.id_rs2        = s.f.rs2;
        bus.id_rd         = s.f.rd;
        bus.id_uses_rs1   = s.uses_rs1;
        bus.id_uses_rs2   = s.uses_rs2;
        bus.id_alu_op     = s.f.alu_op;
        bus.id_alu_src    = s.f.alu_src;
        bus.id_mem_read   = s.f.mem_read;
        bus.id_mem_write  = s.f.mem_write;
        bus.id_reg_write  = s.f.reg_write;
        bus.id_mem_to_reg = s.f.mem_to_reg;
        bus.id_branch     = s.f.branch;
        flush             = s.flush;
        lu = m_ex.valid && m_ex.mem_read && (m_ex.rd != 5'd0) && s.f.valid &&
             ((s.uses_rs1 && (s.f.rs1 == m_ex.rd)) || (s.uses_rs2 && (s.f.rs2 == m_ex.rd)));
        exp_stall = lu && !s.flush;
        if (exp_stall && (m_sc != 2'd3)) m_sc = m_sc + 2'd1;
        if (lu || s.flush) begin
            m_ex = '0;
            if (m_bc != 2'd3) m_bc = m_bc + 2'd1;
        end else if (!s.f.valid) begin
            m_ex = '0;
        end else begin
            m_ex = s.f;
        end
        exp_q.push_back(m_ex);
        cnt_q.push_back({m_sc, m_bc});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(mk(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        checks++;
        if (get_snap() !== snap_t'(0)) begin
            errors++;
            $display("FAIL reset_ex: got %h exp 0", get_snap());
        end
        checks++;
        if ({stall_cnt, bubble_cnt} !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h exp 0", {stall_cnt, bubble_cnt});
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b exp 0", stall);
        end
        rst_n = 1'b1;
        m_ex = '0; m_sc = '0; m_bc = '0;
        exp_q.delete();
        cnt_q.delete();
    endtask

    task automatic test_pass_through();
        stim_t s;
        apply_reset();
        seq.delete();
        s = mk(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        s.f.imm = 32'h10;
        seq.push_back(s);
        seq.push_back(mk(1'b1, 5'd7, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        seq.push_back(mk(1'b0, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0));
        seq.push_back(mk(1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0));
        seq.push_back(mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            #1;
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL pass_stall[%0d]: got %b exp %b", i, stall, exp_stall);
            end
            @(posedge clk);
            #1;
            got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
            checks++;
            if (got !== exp_s) begin
                errors++;
                $display("FAIL pass_ex[%0d]: got %h exp %h", i, got, exp_s);
            end
            checks++;
            if ({stall_cnt, bubble_cnt} !== exp_c) begin
                errors++;
                $display("FAIL pass_cnt[%0d]: got %h exp %h", i, {stall_cnt, bubble_cnt}, exp_c);
            end
            if (i == 0) begin
                checks++;
                if ({bus.ex_valid, bus.ex_rd, bus.ex_imm} !== {1'b1, 5'd5, 32'h10}) begin
                    errors++;
                    $display("FAIL pass_rd5_imm10: got %b/%0d/%h exp 1/5/10",
                             bus.ex_valid, bus.ex_rd, bus.ex_imm);
                end
            end
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        seq.delete();
        seq.push_back(mk(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0)); // lw x6
        seq.push_back(mk(1'b1, 5'd3, 5'd6, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0)); // add rs1=6 -> stall
        seq.push_back(seq[1]);                                              // held add issues
        seq.push_back(mk(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0)); // lw x9
        seq.push_back(mk(1'b1, 5'd4, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0)); // rs2=9 -> stall
        seq.push_back(seq[4]);
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            #1;
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL lu_stall[%0d]: got %b exp %b", i, stall, exp_stall);
            end
            @(posedge clk);
            #1;
            got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
            checks++;
            if (got !== exp_s) begin
                errors++;
                $display("FAIL lu_ex[%0d]: got %h exp %h", i, got, exp_s);
            end
            checks++;
            if ({stall_cnt, bubble_cnt} !== exp_c) begin
                errors++;
                $display("FAIL lu_cnt[%0d]: got %h exp %h", i, {stall_cnt, bubble_cnt}, exp_c);
            end
            if (i == 2) begin
                checks++;
                if ({bus.ex_valid, bus.ex_rd, stall_cnt} !== {1'b1, 5'd3, 2'd1}) begin
                    errors++;
                    $display("FAIL lu_add_issued: got %b/%0d/%0d exp 1/3/1",
                             bus.ex_valid, bus.ex_rd, stall_cnt);
                end
            end
        end
    endtask

    task automatic test_no_false_stall();
        apply_reset();
        seq.delete();
        seq.push_back(mk(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0)); // lw x6
        seq.push_back(mk(1'b1, 5'd3, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0)); // rs=6 but unused
        seq.push_back(mk(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0)); // lw x0
        seq.push_back(mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0)); // reads x0
        seq.push_back(mk(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0)); // non-load rd=7
        seq.push_back(mk(1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0)); // reads x7
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL nofalse_stall[%0d]: got %b exp 0", i, stall);
            end
            @(posedge clk);
            #1;
            got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
            checks++;
            if (got !== exp_s) begin
                errors++;
                $display("FAIL nofalse_ex[%0d]: got %h exp %h", i, got, exp_s);
            end
            checks++;
            if ({stall_cnt, bubble_cnt} !== exp_c) begin
                errors++;
                $display("FAIL nofalse_cnt[%0d]: got %h exp %h", i, {stall_cnt, bubble_cnt}, exp_c);
            end
        end
    endtask

    task automatic test_flush_priority();
        apply_reset();
        seq.delete();
        seq.push_back(mk(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0)); // lw x6
        seq.push_back(mk(1'b1, 5'd3, 5'd6, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1)); // load-use + flush
        seq.push_back(mk(1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0)); // fetch target
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            #1;
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL flush_stall[%0d]: got %b exp %b", i, stall, exp_stall);
            end
            @(posedge clk);
            #1;
            got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
            checks++;
            if (got !== exp_s) begin
                errors++;
                $display("FAIL flush_ex[%0d]: got %h exp %h", i, got, exp_s);
            end
            checks++;
            if ({stall_cnt, bubble_cnt} !== exp_c) begin
                errors++;
                $display("FAIL flush_cnt[%0d]: got %h exp %h", i, {stall_cnt, bubble_cnt}, exp_c);
            end
            if (i == 1) begin
                checks++;
                if ({bus.ex_valid, stall_cnt, bubble_cnt} !== {1'b0, 2'd0, 2'd1}) begin
                    errors++;
                    $display("FAIL flush_only: got valid=%b sc=%0d bc=%0d exp 0/0/1",
                             bus.ex_valid, stall_cnt, bubble_cnt);
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        stim_t add_s;
        apply_reset();
        add_s = mk(1'b1, 5'd3, 5'd6, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        seq.delete();
        seq.push_back(mk(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0));
        seq.push_back(add_s);
        seq.push_back(add_s);
        seq.push_back(mk(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
            checks++;
            if (got !== exp_s) begin
                errors++;
                $display("FAIL rstmid_ex[%0d]: got %h exp %h", i, got, exp_s);
            end
        end
        drive(add_s);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_stall: got %b exp 1", stall);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({get_snap(), stall_cnt, bubble_cnt, stall} !== {snap_t'(0), 2'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_clear: ex=%h sc=%0d bc=%0d stall=%b exp all 0",
                     get_snap(), stall_cnt, bubble_cnt, stall);
        end
        rst_n = 1'b1;
        m_ex = '0; m_sc = '0; m_bc = '0;
        exp_q.delete();
        cnt_q.delete();
        // First edge out of reset loads the waiting instruction normally.
        drive(add_s);
        @(posedge clk);
        #1;
        got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL rstmid_first_load: got %h exp %h", got, exp_s);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        seq.delete();
        for (int k = 0; k < 5; k++) begin
            seq.push_back(mk(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0));
            seq.push_back(mk(1'b1, 5'd3, 5'd6, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0));
            seq.push_back(seq[seq.size() - 1]);
        end
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            #1;
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL sat_stall[%0d]: got %b exp %b", i, stall, exp_stall);
            end
            @(posedge clk);
            #1;
            got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
            checks++;
            if ({stall_cnt, bubble_cnt} !== exp_c) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: got %h exp %h", i, {stall_cnt, bubble_cnt}, exp_c);
            end
        end
        checks++;
        if ({stall_cnt, bubble_cnt} !== {2'd3, 2'd3}) begin
            errors++;
            $display("FAIL sat_hold: got sc=%0d bc=%0d exp 3/3", stall_cnt, bubble_cnt);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        apply_reset();
        seq.delete();
        for (int k = 0; k < 80; k++) begin
            s = mk(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 9) == 0));
            seq.push_back(s);
        end
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            #1;
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL b2b_stall[%0d]: got %b exp %b", i, stall, exp_stall);
            end
            @(posedge clk);
            #1;
            got = get_snap(); exp_s = exp_q.pop_front(); exp_c = cnt_q.pop_front();
            checks++;
            if (got !== exp_s) begin
                errors++;
                $display("FAIL b2b_ex[%0d]: got %h exp %h", i, got, exp_s);
            end
            checks++;
            if ({stall_cnt, bubble_cnt} !== exp_c) begin
                errors++;
                $display("FAIL b2b_cnt[%0d]: got %h exp %h", i, {stall_cnt, bubble_cnt}, exp_c);
            end
        end
        flush = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        m_ex = '0; m_sc = '0; m_bc = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_reset_mid_stall();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
